// File: rtl/frame_fn_eval.sv
// frame_fn_eval: streaming frame reducer.
// Popcounts each accepted WIDTH-bit beat and accumulates over a frame delimited
// by in_last, or force-closed after MAX_BEATS beats. One decision bit (parity,
// majority, all-ones or any-one) is emitted per frame, with the ones count,
// the beat count and an overflow flag. Valid/ready handshakes on both sides.
module frame_fn_eval #(
    parameter int WIDTH     = 5,
    parameter int MAX_BEATS = 8,
    localparam int CW       = $clog2(WIDTH*MAX_BEATS+1),
    localparam int BW       = $clog2(MAX_BEATS+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_f,
    output logic [CW-1:0]    out_count,
    output logic [BW-1:0]    out_beats,
    output logic             out_ovf
);

    localparam int              PCW     = $clog2(WIDTH+1);
    localparam logic [CW:0]     WIDTH_X = (CW+1)'(WIDTH);
    localparam logic [BW-1:0]   MAX_B   = BW'(MAX_BEATS);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    typedef enum logic [1:0] {
        MODE_PARITY = 2'd0,
        MODE_MAJ    = 2'd1,
        MODE_ALL    = 2'd2,
        MODE_ANY    = 2'd3
    } mode_t;

    state_t          state;
    logic [CW-1:0]   acc_q;
    logic [BW-1:0]   beat_q;
    logic [1:0]      mode_q;

    logic [PCW-1:0]  pc;
    logic            accept;
    logic [CW-1:0]   acc_n;
    logic [BW-1:0]   beat_n;
    logic [1:0]      mode_n;
    logic            close;
    logic            ovf_n;
    logic            f_n;
    logic [CW:0]     two_acc;
    logic [CW:0]     beats_x;
    logic [CW:0]     total_bits;

    // A pending result blocks input only while the consumer is stalling it.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Number of ones in the current input beat.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PCW'(in_data[i]);
        end
    end

    // Frame totals including the current beat; the first beat starts fresh and latches the mode.
    always_comb begin
        if (state == IDLE) begin
            acc_n  = CW'(pc);
            beat_n = BW'(1);
            mode_n = in_mode;
        end else begin
            acc_n  = acc_q + CW'(pc);
            beat_n = beat_q + BW'(1);
            mode_n = mode_q;
        end
        close = accept && (in_last || (beat_n == MAX_B));
        ovf_n = !in_last;
    end

    // Reduction decision over the frame totals, compared one bit wider than the counter.
    always_comb begin
        two_acc             = {acc_n, 1'b0};
        beats_x             = '0;
        beats_x[BW-1:0]     = beat_n;
        total_bits          = WIDTH_X * beats_x;
        case (mode_t'(mode_n))
            MODE_PARITY: f_n = acc_n[0];
            MODE_MAJ:    f_n = (two_acc > total_bits);
            MODE_ALL:    f_n = ({1'b0, acc_n} == total_bits);
            default:     f_n = (acc_n != '0);
        endcase
    end

    // Frame FSM, accumulators and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_q     <= '0;
            beat_q    <= '0;
            mode_q    <= '0;
            out_valid <= 1'b0;
            out_f     <= 1'b0;
            out_count <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the later load below overrides the clear.
            if (accept) begin
                acc_q  <= acc_n;
                beat_q <= beat_n;
                mode_q <= mode_n;
                state  <= close ? IDLE : ACC;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (close) begin
                out_valid <= 1'b1;
                out_f     <= f_n;
                out_count <= acc_n;
                out_beats <= beat_n;
                out_ovf   <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_frame_fn_eval.sv
// tb_frame_fn_eval: directed and randomized checks of frame_fn_eval against a
// frame-level reference model (beat queue + plain arithmetic per closed frame).
module tb_frame_fn_eval;

    localparam int W    = 5;
    localparam int MAXB = 4;
    localparam int CW   = $clog2(W*MAXB+1);
    localparam int BW   = $clog2(MAXB+1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_f;
    logic [CW-1:0] out_count;
    logic [BW-1:0] out_beats;
    logic          out_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [W-1:0] q[$];
    logic [1:0]   fmode;
    logic         exp_valid;
    logic         exp_f;
    int           exp_count;
    int           exp_beats;
    logic         exp_ovf;

    frame_fn_eval #(
        .WIDTH     (W),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_count (out_count),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fmode     = 2'd0;
        exp_valid = 1'b0;
        exp_f     = 1'b0;
        exp_count = 0;
        exp_beats = 0;
        exp_ovf   = 1'b0;
    endtask

    // Advance the model by one clock: accept a beat, close the frame if due, handle transfer.
    task automatic model_step(input logic acc, input logic [W-1:0] d, input logic [1:0] m,
                              input logic l, input logic ordy);
        bit closing;
        int cnt;
        int nb;
        bit f;
        closing = 0;
        cnt     = 0;
        nb      = 0;
        f       = 0;
        if (acc) begin
            if (q.size() == 0) fmode = m;
            q.push_back(d);
            if (l || q.size() == MAXB) begin
                closing = 1;
                nb = q.size();
                foreach (q[i]) cnt += $countones(q[i]);
                case (fmode)
                    2'd0: f = (cnt % 2) == 1;
                    2'd1: f = (2 * cnt) > (W * nb);
                    2'd2: f = cnt == (W * nb);
                    default: f = cnt != 0;
                endcase
            end
        end
        if (exp_valid && ordy) exp_valid = 1'b0;
        if (closing) begin
            exp_valid = 1'b1;
            exp_f     = f;
            exp_count = cnt;
            exp_beats = nb;
            exp_ovf   = !l;
            q.delete();
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then step model and clock.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                               input logic l, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_last   = l;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !exp_valid || ordy);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_f", out_f, exp_f);
            check("out_count", out_count, exp_count);
            check("out_beats", out_beats, exp_beats);
            check("out_ovf", out_ovf, exp_ovf);
        end
        model_step(v && (!exp_valid || ordy), d, m, l, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_f"}, out_f, 0);
        check({tag, "_count"}, out_count, 0);
        check({tag, "_beats"}, out_beats, 0);
        check({tag, "_ovf"}, out_ovf, 0);
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat parity frame.
        drive_cycle(1'b1, 5'b00110, 2'd0, 1'b1, 1'b1);
        check("t1_valid", out_valid, 1);
        check("t1_count", out_count, 2);
        idle(1);

        // Majority ties give 0, one more one gives 1.
        drive_cycle(1'b1, 5'b11100, 2'd1, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11000, 2'd1, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'b11100, 2'd1, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11001, 2'd1, 1'b1, 1'b1);
        idle(1);

        // All-ones; mode change on beat 2 is ignored.
        drive_cycle(1'b1, 5'b11111, 2'd2, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11111, 2'd1, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'b11111, 2'd2, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11110, 2'd1, 1'b1, 1'b1);
        idle(1);

        // Force-close at MAX_BEATS, then a fifth beat opens a new frame.
        for (int i = 0; i < MAXB; i++) drive_cycle(1'b1, 5'b00000, 2'd3, 1'b0, 1'b1);
        check("ovf_seen", out_ovf, 1);
        drive_cycle(1'b1, 5'b00001, 2'd3, 1'b1, 1'b1);
        idle(1);

        // Backpressure: result held for 5 cycles, then back-to-back load.
        drive_cycle(1'b1, 5'b10101, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 5'b01111, 2'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'b01111, 2'd0, 1'b1, 1'b1);
        check("b2b_count", out_count, 4);
        idle(1);

        // Reset mid-frame discards the partial frame.
        drive_cycle(1'b1, 5'b11011, 2'd1, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'b00000, 2'd0, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11111, 2'd2, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'b11111, 2'd2, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 5'b00001, 2'd0, 1'b1, 1'b1);
        check("post_rst_f", out_f, 1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 2'($urandom),
                        1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_fn_eval.md
Name: frame_fn_eval

Overview:
- Parametrised, clocked successor to the team's 5-input combinational function example.
- Evaluates a selectable reduction function (parity, majority, all-ones, any-one) over WIDTH-bit input beats.
- Accumulates across a multi-beat frame delimited by in_last, with valid/ready handshakes on both sides.
- Sits between a streaming producer and a consumer that wants one decision bit plus statistics per frame.

Parameters:
- WIDTH, 5, bits per input beat.
- MAX_BEATS, 8, maximum beats per frame; reaching it force-closes the frame.
- CW, $clog2(WIDTH*MAX_BEATS+1), width of the ones counter (derived, not overridden).
- BW, $clog2(MAX_BEATS+1), width of the beat counter (derived, not overridden).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  beat data.
- in_mode  in  2  0=parity, 1=majority, 2=all, 3=any; sampled on first beat of frame only.
- in_last  in  1  final beat of frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_f  out  1  function result for the frame.
- out_count  out  CW  total ones in the frame.
- out_beats  out  BW  beats in the frame.
- out_ovf  out  1  frame was force-closed at MAX_BEATS without in_last.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; acc_cnt, beat_cnt, mode_q cleared; out_valid=0, out_f=0, out_count=0, out_beats=0, out_ovf=0. in_ready=1 once rst_n is high.
- Reset asserted mid-frame discards the partial frame. No result is emitted for it.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result transferred when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational), so there are no bubbles when the consumer is always ready.
- Per-beat popcount: pc = number of ones in in_data, range 0..WIDTH.
- FSM states:
  - IDLE: no frame open. An accepted beat latches mode_q=in_mode and sets acc=pc, beats=1.
    - If in_last=1 or MAX_BEATS==1: close the frame (see below) and stay in IDLE.
    - Else: go to ACC.
  - ACC: an accepted beat adds acc+=pc, beats+=1. in_mode is ignored in this state.
    - If in_last=1: close with ovf=0 and return to IDLE.
    - Else if the new beats==MAX_BEATS: close with ovf=1 and return to IDLE.
- Closing a frame, from the totals including the closing beat: out_valid=1 on the next cycle (latency 1 cycle after the last accepted beat); out_count=acc; out_beats=beats; out_ovf as above; out_f by mode_q:
  - parity: acc[0].
  - majority: 1 iff 2*acc > WIDTH*beats; a tie gives 0. Compare at CW+1 bits.
  - all: 1 iff acc == WIDTH*beats.
  - any: 1 iff acc != 0.
- out_* hold stable while out_valid && !out_ready.
- out_valid clears on the transfer cycle unless a new frame closes in that same cycle; in that case the new result loads back-to-back.
- Counters never wrap: MAX_BEATS bounds beats, and CW is sized for WIDTH*MAX_BEATS.

Test Plan:
- Single beat, WIDTH=5, mode=0, in_data=5'b00110, in_last=1 → next cycle out_valid=1, out_f=0, out_count=2, out_beats=1, out_ovf=0.
- Majority frame 5'b11100 then 5'b11000 (last) → count=5, beats=2, 10>10 false → out_f=0. Repeat with second beat 5'b11001 → count=6, out_f=1.
- Mode=2, beats 5'b11111, 5'b11111 (last) → out_f=1, count=10. Mode change to 1 on beat 2 is ignored: the result still uses all.
- MAX_BEATS=4, mode=3, four beats of 5'b00000 with in_last=0 → out_f=0, out_beats=4, out_ovf=1. A fifth beat opens a new frame.
- Backpressure: hold out_ready=0 after a result → in_ready=0 and out_* stable for 5 cycles. Raise out_ready with a pending closing beat → back-to-back result with no lost beat.
- Pull rst_n low after 2 beats of an open frame → outputs zero immediately. After release, a new single-beat frame 5'b00001 (mode 0) → out_f=1, count=1.
